// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: state encoding and sizing helpers shared by mem_bus_ctrl and its decoder.
package mem_bus_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_region_decode.sv
// region_decode: combinational base/mask address matcher; the lowest matching region index wins.
module region_decode
  import mem_bus_pkg::*;
#(
  parameter int                                ADDR_WIDTH  = 8,
  parameter int                                NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {8'h80, 8'h00},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {8'h80, 8'h80},
  parameter int                                IDX_W       = idx_width(NUM_REGIONS)
) (
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  output logic [NUM_REGIONS-1:0] o_hit,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_miss
);

  logic [NUM_REGIONS-1:0] w_match;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      w_match[i] = ((i_addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                    (REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]));
    end
  end

  // Walk from the top down so the lowest matching index overwrites the rest.
  always_comb begin
    o_idx = '0;
    o_hit = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        o_idx    = IDX_W'(i);
        o_hit    = '0;
        o_hit[i] = 1'b1;
      end
    end
  end

  assign o_miss = ~|w_match;

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: routes CPU memory requests to base/mask decoded slave regions with per-region wait states.
// Optional MEM_BUS_ACK_EN: hold each access for the slave's bus_ack, aborting to a bus error after TIMEOUT cycles.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int                                DATA_WIDTH  = 8,
  parameter int                                ADDR_WIDTH  = 8,
  parameter int                                NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {8'h80, 8'h00},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {8'h80, 8'h80},
  parameter logic [NUM_REGIONS*WAIT_W-1:0]     REGION_WAIT = {4'd2, 4'd0},
  parameter int                                TIMEOUT     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_rd,
  input  logic                              req_wr,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]             req_wdata,
  output logic [DATA_WIDTH-1:0]             req_rdata,
  output logic                              req_ready,
  output logic                              bus_err,
  output logic [NUM_REGIONS-1:0]            bus_cs,
  output logic [ADDR_WIDTH-1:0]             bus_addr,
  output logic [DATA_WIDTH-1:0]             bus_wdata,
  output logic                              bus_we,
  output logic                              bus_re,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] bus_rdata,
  input  logic [NUM_REGIONS-1:0]            bus_ack
);

  localparam int IDX_W = idx_width(NUM_REGIONS);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_REGIONS-1:0] r_cs;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [WAIT_W-1:0]      r_wait;
  logic                   r_re;
  logic                   r_we;
  logic                   r_ready;
  logic                   r_err;

  logic [NUM_REGIONS-1:0] w_hit;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_miss;
  logic [DATA_WIDTH-1:0]  w_sel_rdata;
  logic                   w_last;
  logic                   w_tmo;

  region_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .IDX_W       (IDX_W)
  ) u_decode (
    .i_addr (req_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx),
    .o_miss (w_miss)
  );

  assign w_sel_rdata = bus_rdata[r_idx*DATA_WIDTH +: DATA_WIDTH];

`ifdef MEM_BUS_ACK_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo;

  assign w_last = (r_wait == '0) && bus_ack[r_idx];
  assign w_tmo  = (r_tmo == TMO_W'(TIMEOUT - 1));

  // Watchdog counts every ACCESS cycle, wait states included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
    end else if (r_state == ST_ACCESS) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end
`else
  logic w_unused_ack;

  assign w_last       = (r_wait == '0);
  assign w_tmo        = 1'b0;
  assign w_unused_ack = ^bus_ack ^ TIMEOUT[0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cs    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_wait  <= '0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_rd && req_wr) begin
            r_state <= ST_ERR;
            r_ready <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else if (req_rd || req_wr) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (w_miss) begin
              r_state <= ST_ERR;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_state <= ST_ACCESS;
              r_idx   <= w_idx;
              r_cs    <= w_hit;
              r_re    <= req_rd;
              r_we    <= req_wr;
              r_wait  <= REGION_WAIT[w_idx*WAIT_W +: WAIT_W];
            end
          end
        end
        ST_ACCESS: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            r_cs    <= '0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            if (r_re) begin
              r_rdata <= w_sel_rdata;
            end
          end else if (w_tmo) begin
            r_state <= ST_ERR;
            r_ready <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_cs    <= '0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
          end else if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_rdata = r_rdata;
  assign req_ready = r_ready;
  assign bus_err   = r_err;
  assign bus_cs    = r_cs;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_we    = r_we;
  assign bus_re    = r_re;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: table-driven scoreboard bench for mem_bus_ctrl (two-region default and one-region instance).
module tb_mem_bus_ctrl;

  typedef struct {
    int          dut;
    bit          rd;
    bit          wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  r0;
    logic [7:0]  r1;
    int          ack_cyc;
    logic [1:0]  exp_cs;
    bit          exp_re;
    bit          exp_we;
    int          exp_lat;
    int          exp_strb;
    bit          exp_err;
    logic [7:0]  exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_rd = 1'b0, req_wr = 1'b0;
  logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
  logic [7:0] rd0 = 8'h00, rd1 = 8'h00;
  logic [1:0] ack = 2'b11;
  int         dsel = 0;

  logic u0_rd, u0_wr, u1_rd, u1_wr;
  assign u0_rd = (dsel == 0) && req_rd;
  assign u0_wr = (dsel == 0) && req_wr;
  assign u1_rd = (dsel == 1) && req_rd;
  assign u1_wr = (dsel == 1) && req_wr;

  logic [7:0] u0_rdata, u0_baddr, u0_bwdata, u1_rdata, u1_baddr, u1_bwdata;
  logic       u0_ready, u0_err, u0_we, u0_re, u1_ready, u1_err, u1_we, u1_re;
  logic [1:0] u0_cs;
  logic [0:0] u1_cs;

  mem_bus_ctrl #(.TIMEOUT(4)) u0 (
    .clk(clk), .rst(rst), .req_rd(u0_rd), .req_wr(u0_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rdata(u0_rdata), .req_ready(u0_ready), .bus_err(u0_err),
    .bus_cs(u0_cs), .bus_addr(u0_baddr), .bus_wdata(u0_bwdata), .bus_we(u0_we),
    .bus_re(u0_re), .bus_rdata({rd1, rd0}), .bus_ack(ack)
  );

  mem_bus_ctrl #(
    .NUM_REGIONS(1), .REGION_BASE(8'h00), .REGION_MASK(8'h80), .REGION_WAIT(4'd0), .TIMEOUT(4)
  ) u1 (
    .clk(clk), .rst(rst), .req_rd(u1_rd), .req_wr(u1_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rdata(u1_rdata), .req_ready(u1_ready), .bus_err(u1_err),
    .bus_cs(u1_cs), .bus_addr(u1_baddr), .bus_wdata(u1_bwdata), .bus_we(u1_we),
    .bus_re(u1_re), .bus_rdata(rd0), .bus_ack(ack[0])
  );

  logic [7:0] m_rdata, m_baddr, m_bwdata;
  logic       m_ready, m_err, m_we, m_re;
  logic [1:0] m_cs;
  assign m_rdata  = (dsel == 1) ? u1_rdata  : u0_rdata;
  assign m_baddr  = (dsel == 1) ? u1_baddr  : u0_baddr;
  assign m_bwdata = (dsel == 1) ? u1_bwdata : u0_bwdata;
  assign m_ready  = (dsel == 1) ? u1_ready  : u0_ready;
  assign m_err    = (dsel == 1) ? u1_err    : u0_err;
  assign m_we     = (dsel == 1) ? u1_we     : u0_we;
  assign m_re     = (dsel == 1) ? u1_re     : u0_re;
  assign m_cs     = (dsel == 1) ? {1'b0, u1_cs} : u0_cs;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int dut, input bit rd, input bit wr, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic [7:0] r0, input logic [7:0] r1,
                              input int ackc, input logic [1:0] cs, input bit re, input bit we,
                              input int lat, input int strb, input bit err, input logic [7:0] rdata);
    vec_t v;
    v.dut = dut; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.r0 = r0; v.r1 = r1;
    v.ack_cyc = ackc; v.exp_cs = cs; v.exp_re = re; v.exp_we = we; v.exp_lat = lat;
    v.exp_strb = strb; v.exp_err = err; v.exp_rdata = rdata;
    return v;
  endfunction

  task automatic do_txn(input vec_t v, input string tag);
    vec_t e;
    bit   got;
    int   strb;
    got  = 1'b0;
    strb = 0;
    @(negedge clk);
    dsel = v.dut; req_rd = v.rd; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    rd0 = v.r0; rd1 = v.r1;
    ack = (v.ack_cyc == 0) ? 2'b11 : 2'b00;
    sb.push_back(v);
    @(posedge clk);
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (v.ack_cyc != 0 && c >= v.ack_cyc) ack = 2'b11;
      if (m_ready) begin
        got = 1'b1;
        e = sb.pop_front();
        chk($sformatf("%s_latency", tag), 32'(c), 32'(e.exp_lat));
        chk($sformatf("%s_strobe_cycles", tag), 32'(strb), 32'(e.exp_strb));
        chk($sformatf("%s_bus_err", tag), 32'(m_err), 32'(e.exp_err));
        chk($sformatf("%s_req_rdata", tag), 32'(m_rdata), 32'(e.exp_rdata));
        chk($sformatf("%s_idle_bus", tag), 32'({m_cs, m_re, m_we}), 32'(0));
        req_rd = 1'b0;
        req_wr = 1'b0;
      end else begin
        chk($sformatf("%s_c%0d_cs", tag, c), 32'(m_cs), 32'(v.exp_cs));
        chk($sformatf("%s_c%0d_re_we", tag, c), 32'({m_re, m_we}), 32'({v.exp_re, v.exp_we}));
        if (m_re || m_we) begin
          strb++;
          chk($sformatf("%s_c%0d_addr", tag, c), 32'(m_baddr), 32'(v.addr));
          if (v.wr) chk($sformatf("%s_c%0d_wdata", tag, c), 32'(m_bwdata), 32'(v.wdata));
        end
      end
    end
    if (!got) begin
      chk($sformatf("%s_ready_timeout", tag), 32'(0), 32'(1));
      sb.delete();
      req_rd = 1'b0;
      req_wr = 1'b0;
    end
  endtask

  vec_t vt[9];

  initial begin
    bit seen;
    vt[0] = mk(0, 1, 0, 8'h05, 8'h00, 8'hA5, 8'h11, 0, 2'b01, 1, 0, 2, 1, 0, 8'hA5);
    vt[1] = mk(0, 0, 1, 8'h90, 8'h3C, 8'h22, 8'h33, 0, 2'b10, 0, 1, 4, 3, 0, 8'hA5);
    vt[2] = mk(0, 1, 0, 8'h90, 8'h00, 8'h44, 8'h5A, 0, 2'b10, 1, 0, 4, 3, 0, 8'h5A);
    vt[3] = mk(0, 1, 0, 8'h7F, 8'h00, 8'hC3, 8'h99, 0, 2'b01, 1, 0, 2, 1, 0, 8'hC3);
    vt[4] = mk(0, 1, 1, 8'h10, 8'h55, 8'h66, 8'h77, 0, 2'b00, 0, 0, 1, 0, 1, 8'h00);
    vt[5] = mk(0, 0, 1, 8'h00, 8'hFF, 8'h12, 8'h34, 0, 2'b01, 0, 1, 2, 1, 0, 8'h00);
    vt[6] = mk(0, 1, 0, 8'h80, 8'h00, 8'h18, 8'h81, 0, 2'b10, 1, 0, 4, 3, 0, 8'h81);
    vt[7] = mk(1, 1, 0, 8'hF0, 8'h00, 8'hEE, 8'h00, 0, 2'b00, 0, 0, 1, 0, 1, 8'h00);
    vt[8] = mk(1, 1, 0, 8'h10, 8'h00, 8'h77, 8'h00, 0, 2'b01, 1, 0, 2, 1, 0, 8'h77);

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_u0", 32'({u0_ready, u0_err, u0_cs, u0_we, u0_re, u0_rdata, u0_baddr, u0_bwdata}), 32'(0));
    chk("reset_outputs_u1", 32'({u1_ready, u1_err, u1_cs, u1_we, u1_re, u1_rdata}), 32'(0));
    rst = 1'b1;

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("idle_%0d", k), 32'({u0_ready, u0_cs, u0_re, u0_we}), 32'(0));
    end

    foreach (vt[i]) do_txn(vt[i], $sformatf("vec%0d", i));

    // Reset during the second wait cycle of a region-1 write.
    @(negedge clk);
    dsel = 0; req_wr = 1'b1; req_addr = 8'h90; req_wdata = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_we_before", 32'({u0_we, u0_cs}), 32'({1'b1, 2'b10}));
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_we_async", 32'({u0_we, u0_re, u0_cs}), 32'(0));
    req_wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (u0_ready || u0_cs != 2'b00) seen = 1'b1;
    end
    chk("rst_mid_no_ready", 32'(seen), 32'(0));
    do_txn(vt[0], "after_rst");

`ifdef MEM_BUS_ACK_EN
    do_txn(mk(0, 1, 0, 8'h05, 8'h00, 8'h6B, 8'h00, 99, 2'b01, 1, 0, 5, 4, 1, 8'h00), "ack_timeout");
    do_txn(mk(0, 1, 0, 8'h05, 8'h00, 8'h6B, 8'h00, 2, 2'b01, 1, 0, 3, 2, 0, 8'h6B), "ack_cycle2");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Parametrised memory-interface controller between the CPU datapath's memory request (address, write data, read/write strobes) and up to NUM_REGIONS memory-mapped slaves (RAM, peripherals).
- Decodes each request against per-region base/mask pairs.
- Inserts per-region wait states and registers read data.
- Returns a one-cycle ready pulse so the control unit can stall.
- Flags accesses to unmapped addresses as bus errors.

Parameters:
DATA_WIDTH, 8, data bus width in bits
ADDR_WIDTH, 8, address bus width in bits
NUM_REGIONS, 2, number of decoded slave regions (1..8)
REGION_BASE, {8'h80, 8'h00}, packed NUM_REGIONS*ADDR_WIDTH; region i base at slice i
REGION_MASK, {8'h80, 8'h80}, packed NUM_REGIONS*ADDR_WIDTH; region i hits when (addr & mask_i) == (base_i & mask_i)
REGION_WAIT, {4'd2, 4'd0}, packed NUM_REGIONS*4; extra wait cycles per region (0..15)
TIMEOUT, 16, max cycles awaiting bus_ack (used only with MEM_BUS_ACK_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_rd  in  1  read request from control word
req_wr  in  1  write request from control word
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
req_rdata  out  DATA_WIDTH  registered read data, valid with req_ready
req_ready  out  1  one-cycle completion pulse
bus_err  out  1  one-cycle error pulse, coincident with req_ready
bus_cs  out  NUM_REGIONS  one-hot slave select
bus_addr  out  ADDR_WIDTH  latched address to slaves
bus_wdata  out  DATA_WIDTH  latched write data
bus_we  out  1  write strobe
bus_re  out  1  read strobe
bus_rdata  in  NUM_REGIONS*DATA_WIDTH  per-region read data, region i at slice i
bus_ack  in  NUM_REGIONS  per-region slave acknowledge (ignored unless MEM_BUS_ACK_EN)

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; internal latches and counters 0.
- IDLE: if req_rd^req_wr, latch addr, wdata, direction and decoded region, then go to ACCESS.
  - No region hits → ERR.
  - req_rd & req_wr both high → ERR; no slave is strobed.
  - Neither high → remain in IDLE.
- Decode: priority by lowest region index when regions overlap; result is one-hot.
- ACCESS: bus_cs[region], bus_addr, bus_wdata driven from latches; bus_re or bus_we high for REGION_WAIT[region]+1 cycles (wait counter loads in IDLE, decrements each cycle). On the final cycle, capture bus_rdata[region] into req_rdata (reads only; writes leave req_rdata unchanged), then go to DONE.
- DONE: req_ready=1 for exactly one cycle; all strobes and bus_cs low; next state IDLE. Earliest back-to-back request is accepted in the cycle after DONE.
- ERR: req_ready=1 and bus_err=1 for one cycle; req_rdata forced to 0; next state IDLE.
- Latency, request sample to req_ready: WAIT+2 cycles.
- Request inputs are ignored outside IDLE. The CPU holds its request until it sees req_ready.
- Reset mid-access: strobes drop immediately (async); no ready pulse follows.

Optional Feature:
Macro MEM_BUS_ACK_EN.
- Defined: after the fixed wait count expires, ACCESS holds until bus_ack[region]=1 (data captured that cycle). A TIMEOUT-cycle counter starts at ACCESS entry; expiry goes to ERR (bus_err=1, req_rdata=0) with strobes dropped.
- Undefined: bus_ack ignored, no timeout counter; fixed wait states only.

Decomposition:
- Shared package mem_bus_pkg: state encoding (IDLE, ACCESS, DONE, ERR), WAIT_W=4 constant, region index width function (clog2 of NUM_REGIONS).
- One sub-module: region_decode, combinational priority base/mask matcher. Outputs: one-hot hit vector, region index, miss flag.

Test Plan:
- Default params, read addr 8'h05 (region 0, wait 0), bus_rdata slice0=8'hA5 → bus_re/bus_cs=2'b01 for 1 cycle; req_ready 2 cycles after sample; req_rdata=8'hA5; bus_err=0.
- Write addr 8'h90 (region 1, wait 2), wdata 8'h3C → bus_we and bus_cs=2'b10 for 3 cycles; bus_wdata=8'h3C; req_ready at cycle 4.
- NUM_REGIONS=1, base 8'h00, mask 8'h80, read 8'hF0 → no strobes; req_ready=bus_err=1 next cycle; req_rdata=0.
- req_rd=req_wr=1 at 8'h10 → ERR pulse; bus_cs stays 0.
- Assert rst=0 during the second wait cycle of a region-1 write → bus_we/bus_cs drop without waiting for a clock edge; state IDLE; no req_ready afterwards.
- MEM_BUS_ACK_EN, TIMEOUT=4, bus_ack held 0 → bus_err pulse 4 cycles after ACCESS entry. Repeat with bus_ack=1 at cycle 2 → normal ready with captured data.
